adc_bitslip_align: RTL and testbench
====================================

Name: adc_bitslip_align

Overview:
- Word-alignment training controller for the 8-lane ADC deserializer: 8 lanes x 8 bits, one shared bitslip strobe.
- Runs in the divclk domain.
- Compares every deserialized byte lane against a known ADC training pattern. Pulses bitslip one position at a time until all lanes match for a qualifying run of cycles, then reports lock. Reports failure if no match is found after all bit positions are tried.
- Sits between the deserializer and the acquisition/config logic, which starts training after ADC test-pattern mode is enabled.

Parameters:
- SETTLE_CYCLES, 16, divclk cycles ignored after start or after each bitslip pulse before comparing; legal 1..255.
- MATCH_CYCLES, 8, consecutive all-lane matching cycles required to declare lock; legal 1..255.
- MAX_SLIPS, 7, maximum bitslip pulses issued before declaring failure; 7 covers all 8 positions of an 8-bit word; legal 0..15.

Ports:
- divclk  in  1  deserializer parallel-word clock; sole clock of the block.
- rst  in  1  synchronous reset, active high.
- start  in  1  begin or restart training; sampled on divclk edge.
- train_pattern  in  8  expected byte on every lane; latched when start is accepted.
- data_deser  in  64  deserialized word; lane k = data_deser[8k+7:8k], k = 0..7.
- bitslip  out  1  to deserializer bitslip input; single-cycle pulses.
- busy  out  1  training in progress.
- locked  out  1  alignment achieved.
- fail  out  1  no alignment found within MAX_SLIPS slips.
- slip_count  out  4  number of bitslip pulses issued in the current or last training run.

Behaviour:
- Reset: state IDLE. bitslip=0, busy=0, locked=0, fail=0, slip_count=0, internal counters 0, latched pattern 0.
- rst takes priority over all inputs at any time, including mid-pulse: bitslip is 0 on the cycle after the reset edge.
- All outputs are registered.

States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE/LOCKED/FAIL with start=1:
  - latch train_pattern
  - clear locked, fail, slip_count, settle counter and match counter
  - busy=1, go to SETTLE.
- start while busy=1 (SETTLE/CHECK/SLIP) is ignored.
- SETTLE: stays exactly SETTLE_CYCLES cycles; data ignored; then CHECK.
- CHECK: match = all 8 lanes equal the latched pattern in the current cycle (combinational compare of data_deser).
  - match: increment match counter. When the counter reaches MATCH_CYCLES, go to LOCKED.
  - mismatch: clear match counter. If slip_count < MAX_SLIPS, go to SLIP; else go to FAIL.
- SLIP: bitslip=1 for exactly this one cycle; slip_count increments by 1 on this edge; match and settle counters cleared; then SETTLE.
  - Consecutive bitslip pulses are therefore separated by at least SETTLE_CYCLES+1 low cycles.
- LOCKED: busy=0, locked=1. Holds until start or rst. No loss-of-lock monitoring; data mismatches are ignored.
- FAIL: busy=0, fail=1, slip_count=MAX_SLIPS. Holds until start or rst.
- locked and fail are never both 1. busy=1 exactly in SETTLE, CHECK and SLIP.

Timing and latency:
- start accepted at edge t: SETTLE occupies cycles t+1..t+S, CHECK begins at t+S+1.
- With no slips, locked=1 and busy=0 from cycle t+S+M+1 (S=SETTLE_CYCLES, M=MATCH_CYCLES).
- Each slip adds 1 (SLIP) + S cycles, plus the CHECK cycles consumed up to the mismatch.
- MAX_SLIPS=0: a first mismatch goes directly to FAIL with no bitslip pulse.
- Counter widths are sized to the parameter maxima; no wrap is possible within legal ranges.

Test Plan:
1. Already aligned: S=16, M=8, all lanes 0xA5, start with pattern 0xA5 at cycle 0 -> busy=1 from cycle 1; locked=1, busy=0 at cycle 25; bitslip never high; slip_count=0.
2. Offset 3: lane model rotates one bit per bitslip, initial offset 3, pattern 0x5C -> exactly 3 single-cycle bitslip pulses, each gap >=17 cycles; then locked=1, slip_count=3, fail=0.
3. Never matches: data constant 0x00, pattern 0xFF -> exactly 7 bitslip pulses, then fail=1, busy=0, locked=0, slip_count=7; no 8th pulse within 100 further cycles.
4. Partial match: all lanes match for 5 cycles, then lane 6 = 0x00 for one cycle -> SLIP taken (bitslip pulse, slip_count=1); after resettle, 8 clean matches -> locked.
5. Reset and restart:
   - rst asserted on the SLIP cycle -> next cycle bitslip=0, busy=0, slip_count=0.
   - start pulsed during SETTLE -> ignored; training timeline unchanged.
   - start in LOCKED -> locked=0 next cycle, busy=1, new pattern latched.

Source files
------------

// File: rtl/adc_bitslip_align_if.sv
// Signal bundle between the ADC deserializer/config logic and the bitslip alignment controller.
// The slave modport is the controller's view; master is the driving side.
interface adc_bitslip_align_if;
    logic        start;
    logic [7:0]  train_pattern;
    logic [63:0] data_deser;
    logic        bitslip;
    logic        busy;
    logic        locked;
    logic        fail;
    logic [3:0]  slip_count;

    modport master (
        output start, train_pattern, data_deser,
        input  bitslip, busy, locked, fail, slip_count
    );

    modport slave (
        input  start, train_pattern, data_deser,
        output bitslip, busy, locked, fail, slip_count
    );
endinterface

// File: rtl/adc_bitslip_align.sv
// Word-alignment training for an 8-lane x 8-bit ADC deserializer: slips one bit at a time
// until every lane shows the training pattern for MATCH_CYCLES consecutive cycles.
module adc_bitslip_align #(
    parameter int SETTLE_CYCLES = 16,
    parameter int MATCH_CYCLES  = 8,
    parameter int MAX_SLIPS     = 7
) (
    input logic                 divclk,
    input logic                 rst,
    adc_bitslip_align_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } state_e;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CYCLES - 1);
    localparam logic [3:0] SLIP_LIMIT  = 4'(MAX_SLIPS);

    state_e      state_q, state_d;
    logic [7:0]  settleCnt_q, settleCnt_d;
    logic [7:0]  matchCnt_q, matchCnt_d;
    logic [3:0]  slipCnt_q, slipCnt_d;
    logic [7:0]  pattern_q, pattern_d;
    logic        bitslip_q, bitslip_d;
    logic        busy_q, busy_d;
    logic        locked_q, locked_d;
    logic        fail_q, fail_d;
    logic        allMatch;

    always_comb begin
        allMatch = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (bus.data_deser[8*k +: 8] != pattern_q) begin
                allMatch = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        matchCnt_d  = matchCnt_q;
        slipCnt_d   = slipCnt_q;
        pattern_d   = pattern_q;

        case (state_q)
            IDLE, LOCKED, FAIL: begin
                if (bus.start) begin
                    pattern_d   = bus.train_pattern;
                    settleCnt_d = '0;
                    matchCnt_d  = '0;
                    slipCnt_d   = '0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (settleCnt_q == SETTLE_LAST) begin
                    settleCnt_d = '0;
                    state_d     = CHECK;
                end else begin
                    settleCnt_d = settleCnt_q + 8'd1;
                end
            end
            CHECK: begin
                if (allMatch) begin
                    matchCnt_d = matchCnt_q + 8'd1;
                    if (matchCnt_q == MATCH_LAST) begin
                        state_d = LOCKED;
                    end
                end else begin
                    matchCnt_d = '0;
                    state_d    = (slipCnt_q < SLIP_LIMIT) ? SLIP : FAIL;
                end
            end
            SLIP: begin
                slipCnt_d   = slipCnt_q + 4'd1;
                matchCnt_d  = '0;
                settleCnt_d = '0;
                state_d     = SETTLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        bitslip_d = (state_d == SLIP);
        busy_d    = (state_d == SETTLE) || (state_d == CHECK) || (state_d == SLIP);
        locked_d  = (state_d == LOCKED);
        fail_d    = (state_d == FAIL);
    end

    always_ff @(posedge divclk) begin
        if (rst) begin
            state_q     <= IDLE;
            settleCnt_q <= '0;
            matchCnt_q  <= '0;
            slipCnt_q   <= '0;
            pattern_q   <= '0;
            bitslip_q   <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
            matchCnt_q  <= matchCnt_d;
            slipCnt_q   <= slipCnt_d;
            pattern_q   <= pattern_d;
            bitslip_q   <= bitslip_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.bitslip    = bitslip_q;
    assign bus.busy       = busy_q;
    assign bus.locked     = locked_q;
    assign bus.fail       = fail_q;
    assign bus.slip_count = slipCnt_q;

endmodule

// File: tb/tb_adc_bitslip_align.sv
// Directed bench for adc_bitslip_align: default-parameter instance plus a MAX_SLIPS=0 instance
// sharing the same stimulus; cycle numbers count from the cycle in which start is driven.
module tb_adc_bitslip_align;

    logic        divclk = 1'b0;
    logic        rst = 1'b1;
    logic        startDrv = 1'b0;
    logic [7:0]  patDrv = 8'h00;
    logic [63:0] forcedWord = 64'h0;
    logic        modelEn = 1'b0;
    int          modelBase = 0;
    logic [2:0]  modelOffset;
    logic [63:0] dataWord;

    int   cyc = 0;
    int   pulseCount = 0;
    int   pulseCount0 = 0;
    int   widthViol = 0;
    int   gapViol = 0;
    int   lastPulseCyc = -1000;
    logic prevSlip = 1'b0;

    int checks = 0;
    int passes = 0;

    always #5 divclk = ~divclk;

    adc_bitslip_align_if bus();
    adc_bitslip_align_if bus0();

    adc_bitslip_align #(.SETTLE_CYCLES(16), .MATCH_CYCLES(8), .MAX_SLIPS(7)) dut (
        .divclk (divclk),
        .rst    (rst),
        .bus    (bus)
    );

    adc_bitslip_align #(.SETTLE_CYCLES(2), .MATCH_CYCLES(1), .MAX_SLIPS(0)) dutZero (
        .divclk (divclk),
        .rst    (rst),
        .bus    (bus0)
    );

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    // Lane model: each observed bitslip pulse moves the word one bit closer to alignment.
    assign modelOffset = 3'(3 - (pulseCount - modelBase));
    assign dataWord    = modelEn ? {8{rotl8(8'h5C, modelOffset)}} : forcedWord;

    assign bus.start          = startDrv;
    assign bus.train_pattern  = patDrv;
    assign bus.data_deser     = dataWord;
    assign bus0.start         = startDrv;
    assign bus0.train_pattern = patDrv;
    assign bus0.data_deser    = dataWord;

    always @(posedge divclk) begin
        cyc      <= cyc + 1;
        prevSlip <= bus.bitslip;
        if (bus.bitslip) begin
            pulseCount <= pulseCount + 1;
            if (prevSlip) widthViol <= widthViol + 1;
            if (cyc - lastPulseCyc < 18) gapViol <= gapViol + 1;
            lastPulseCyc <= cyc;
        end
        if (bus0.bitslip) pulseCount0 <= pulseCount0 + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [7:0] pat);
        startDrv = st;
        patDrv   = pat;
        @(negedge divclk);
        startDrv = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge divclk);
        rst = 1'b0;
    endtask

    task automatic waitForDone(input int limit, output int n);
        n = 0;
        while (!(bus.locked || bus.fail) && n < limit) begin
            @(negedge divclk);
            n++;
        end
        if (n >= limit) checkOutput("done_timeout", 64'(n), 64'(0));
    endtask

    initial begin
        int n;
        int basePulses;
        int baseGap;
        int baseWidth;

        repeat (3) @(negedge divclk);

        // Test 1: already aligned
        forcedWord = {8{8'hA5}};
        doReset();
        checkOutput("rst_bitslip", bus.bitslip, 1'b0);
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_locked", bus.locked, 1'b0);
        checkOutput("rst_fail", bus.fail, 1'b0);
        checkOutput("rst_slip_count", bus.slip_count, 4'd0);
        basePulses = pulseCount;
        applyStimulus(1'b1, 8'hA5);
        checkOutput("t1_busy_c1", bus.busy, 1'b1);
        checkOutput("t1_locked_c1", bus.locked, 1'b0);
        waitForDone(200, n);
        checkOutput("t1_lock_latency", 64'(n), 64'(24));
        checkOutput("t1_locked", bus.locked, 1'b1);
        checkOutput("t1_busy", bus.busy, 1'b0);
        checkOutput("t1_fail", bus.fail, 1'b0);
        checkOutput("t1_slip_count", bus.slip_count, 4'd0);
        checkOutput("t1_pulses", 64'(pulseCount - basePulses), 64'(0));

        // Test 2: rotating lane model, offset 3
        modelEn = 1'b1;
        doReset();
        modelBase  = pulseCount;
        basePulses = pulseCount;
        baseGap    = gapViol;
        baseWidth  = widthViol;
        applyStimulus(1'b1, 8'h5C);
        waitForDone(400, n);
        checkOutput("t2_lock_latency", 64'(n), 64'(78));
        checkOutput("t2_locked", bus.locked, 1'b1);
        checkOutput("t2_fail", bus.fail, 1'b0);
        checkOutput("t2_slip_count", bus.slip_count, 4'd3);
        checkOutput("t2_pulses", 64'(pulseCount - basePulses), 64'(3));
        checkOutput("t2_gap_viol", 64'(gapViol - baseGap), 64'(0));
        checkOutput("t2_width_viol", 64'(widthViol - baseWidth), 64'(0));
        modelEn = 1'b0;

        // Test 3: never matches
        forcedWord = 64'h0;
        doReset();
        basePulses = pulseCount;
        baseGap    = gapViol;
        applyStimulus(1'b1, 8'hFF);
        waitForDone(400, n);
        checkOutput("t3_fail_latency", 64'(n), 64'(143));
        checkOutput("t3_fail", bus.fail, 1'b1);
        checkOutput("t3_busy", bus.busy, 1'b0);
        checkOutput("t3_locked", bus.locked, 1'b0);
        checkOutput("t3_slip_count", bus.slip_count, 4'd7);
        checkOutput("t3_pulses", 64'(pulseCount - basePulses), 64'(7));
        checkOutput("t3_gap_viol", 64'(gapViol - baseGap), 64'(0));
        repeat (100) @(negedge divclk);
        checkOutput("t3_no_8th_pulse", 64'(pulseCount - basePulses), 64'(7));
        checkOutput("t3_fail_holds", bus.fail, 1'b1);

        // Test 4: five matches, lane 6 glitch, then clean
        forcedWord = {8{8'h3C}};
        doReset();
        basePulses = pulseCount;
        applyStimulus(1'b1, 8'h3C);
        repeat (21) @(negedge divclk);
        forcedWord[55:48] = 8'h00;
        @(negedge divclk);
        forcedWord = {8{8'h3C}};
        checkOutput("t4_slip_pulse", bus.bitslip, 1'b1);
        @(negedge divclk);
        checkOutput("t4_pulse_end", bus.bitslip, 1'b0);
        checkOutput("t4_slip_count_1", bus.slip_count, 4'd1);
        checkOutput("t4_busy", bus.busy, 1'b1);
        waitForDone(200, n);
        checkOutput("t4_lock_latency", 64'(n), 64'(24));
        checkOutput("t4_locked", bus.locked, 1'b1);
        checkOutput("t4_slip_count", bus.slip_count, 4'd1);
        checkOutput("t4_pulses", 64'(pulseCount - basePulses), 64'(1));

        // Test 5a: reset on the SLIP cycle
        forcedWord = 64'h0;
        doReset();
        applyStimulus(1'b1, 8'hFF);
        repeat (17) @(negedge divclk);
        checkOutput("t5a_in_slip", bus.bitslip, 1'b1);
        rst = 1'b1;
        @(negedge divclk);
        rst = 1'b0;
        checkOutput("t5a_bitslip", bus.bitslip, 1'b0);
        checkOutput("t5a_busy", bus.busy, 1'b0);
        checkOutput("t5a_slip_count", bus.slip_count, 4'd0);

        // Test 5b: start during SETTLE is ignored
        forcedWord = {8{8'hA5}};
        applyStimulus(1'b1, 8'hA5);
        repeat (4) @(negedge divclk);
        applyStimulus(1'b1, 8'h00);
        waitForDone(200, n);
        checkOutput("t5b_lock_latency", 64'(n), 64'(19));
        checkOutput("t5b_locked", bus.locked, 1'b1);
        checkOutput("t5b_slip_count", bus.slip_count, 4'd0);

        // Test 5c: restart from LOCKED with a new pattern
        forcedWord = {8{8'h96}};
        repeat (3) @(negedge divclk);
        checkOutput("t5c_lock_holds", bus.locked, 1'b1);
        applyStimulus(1'b1, 8'h96);
        checkOutput("t5c_locked_cleared", bus.locked, 1'b0);
        checkOutput("t5c_busy", bus.busy, 1'b1);
        waitForDone(200, n);
        checkOutput("t5c_lock_latency", 64'(n), 64'(24));
        checkOutput("t5c_slip_count", bus.slip_count, 4'd0);

        // Test 6: MAX_SLIPS=0 fails straight from the first mismatch
        forcedWord = 64'h0;
        doReset();
        basePulses = pulseCount0;
        applyStimulus(1'b1, 8'hFF);
        repeat (2) @(negedge divclk);
        checkOutput("t6_fail_c3", bus0.fail, 1'b0);
        checkOutput("t6_busy_c3", bus0.busy, 1'b1);
        @(negedge divclk);
        checkOutput("t6_fail", bus0.fail, 1'b1);
        checkOutput("t6_busy", bus0.busy, 1'b0);
        checkOutput("t6_slip_count", bus0.slip_count, 4'd0);
        checkOutput("t6_pulses", 64'(pulseCount0 - basePulses), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
